dsm_capture_buffer: RTL and testbench

Parametrised single-clock capture/playback buffer for delta-sigma modulator bitstreams. It records up to DEPTH words of MOD_BITS-wide modulator output through a valid/ready input port. On command it replays the recorded words in order through a valid/ready output port, either once or continuously. It sits between a modulator source (external part model or on-chip DSM) and the decimation/analysis path, and generalises the fixed 4-bit, 256-entry, free-running buffer to arbitrary width and depth with explicit arm/play/abort control.

---
 rtl/dsm_capture_buffer.sv | 189 ++++++++++++++++++
 tb/tb_dsm_capture_buffer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsm_capture_buffer.sv
// dsm_capture_buffer: capture/playback buffer for delta-sigma modulator bitstreams.
// Records up to DEPTH words of MOD_BITS width through a valid/ready input port. On play it
// replays them in write order through a registered valid/ready output port.
// Optional feature macro: DSM_BUF_LOOP_EN -- when defined, playback wraps continuously
// (done pulses once per wrap) until abort; when undefined, playback is one-shot.
//
// Ports:
//   internal_clk, internal_rst   clock, synchronous active-high reset
//   arm, play, abort             command pulses (priority abort > arm > play)
//   in_valid, in_bits, in_ready  capture port
//   out_valid, out_bits, out_ready  playback port (out_bits = IDLE_CODE when not valid)
//   fill_level                   captured word count, 0..DEPTH
//   state                        IDLE=0, CAPTURE=1, READY=2, PLAY=3
//   overflow                     sticky, a word was offered in READY or PLAY
//   done                         one-cycle pulse after the last word is accepted
module dsm_capture_buffer #(
    parameter int unsigned          MOD_BITS  = 4,
    parameter int unsigned          DEPTH     = 256,
    parameter logic [MOD_BITS-1:0]  IDLE_CODE = {MOD_BITS{1'b0}},
    localparam int unsigned         AW        = $clog2(DEPTH)
) (
    input  logic                internal_clk,
    input  logic                internal_rst,
    input  logic                arm,
    input  logic                play,
    input  logic                abort,
    input  logic                in_valid,
    input  logic [MOD_BITS-1:0] in_bits,
    output logic                in_ready,
    output logic                out_valid,
    output logic [MOD_BITS-1:0] out_bits,
    input  logic                out_ready,
    output logic [AW:0]         fill_level,
    output logic [1:0]          state,
    output logic                overflow,
    output logic                done
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StReady   = 2'd2,
        StPlay    = 2'd3
    } state_e;

    localparam logic [AW:0] LastFill = (AW+1)'(DEPTH - 1);
`ifdef DSM_BUF_LOOP_EN
    localparam logic [AW-1:0] FirstIdx = '0;
`endif

    state_e              state_q, state_d;
    logic [AW:0]         fill_q, fill_d;
    // Index of the next word to load into the output register.
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic                overflow_q, overflow_d;
    logic                done_q, done_d;
    logic                out_valid_q, out_valid_d;
    logic [MOD_BITS-1:0] out_bits_q, out_bits_d;
    logic                wr_en;
    logic                xfer;
    logic                all_loaded;

    logic [MOD_BITS-1:0] mem [DEPTH];

    assign xfer       = out_valid_q & out_ready;
    assign all_loaded = (rd_ptr_q == fill_q);

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_bits_d  = out_bits_q;
        wr_en       = 1'b0;

        if (in_valid && (state_q == StReady || state_q == StPlay)) begin
            overflow_d = 1'b1;
        end

        if (abort) begin
            state_d     = StIdle;
            fill_d      = '0;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
            out_bits_d  = IDLE_CODE;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arm) begin
                        state_d    = StCapture;
                        fill_d     = '0;
                        overflow_d = 1'b0;
                    end
                end
                StCapture: begin
                    if (arm) begin
                        // Restart: any word offered this cycle belongs to the old capture.
                        fill_d     = '0;
                        overflow_d = 1'b0;
                    end else begin
                        wr_en = in_valid;
                        if (in_valid) begin
                            fill_d = fill_q + 1'b1;
                        end
                        if (play && (fill_q != '0 || in_valid)) begin
                            state_d  = StPlay;
                            rd_ptr_d = '0;
                        end else if (in_valid && fill_q == LastFill) begin
                            state_d = StReady;
                        end
                    end
                end
                StReady: begin
                    if (arm) begin
                        state_d    = StCapture;
                        fill_d     = '0;
                        overflow_d = 1'b0;
                    end else if (play) begin
                        state_d  = StPlay;
                        rd_ptr_d = '0;
                    end
                end
                StPlay: begin
                    // Refill the output register when it is empty or being drained.
                    if (!out_valid_q || xfer) begin
                        if (!all_loaded) begin
                            out_bits_d  = mem[rd_ptr_q[AW-1:0]];
                            out_valid_d = 1'b1;
                            rd_ptr_d    = rd_ptr_q + 1'b1;
                        end else begin
`ifdef DSM_BUF_LOOP_EN
                            done_d      = xfer;
                            out_bits_d  = mem[FirstIdx];
                            out_valid_d = 1'b1;
                            rd_ptr_d    = (AW+1)'(1);
`else
                            out_valid_d = 1'b0;
                            out_bits_d  = IDLE_CODE;
                            if (xfer) begin
                                done_d  = 1'b1;
                                state_d = StReady;
                            end
`endif
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge internal_clk) begin
        if (internal_rst) begin
            state_q     <= StIdle;
            fill_q      <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_bits_q  <= IDLE_CODE;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
        end
    end

    // Storage is deliberately not reset; only captured entries are ever read.
    always_ff @(posedge internal_clk) begin
        if (wr_en) begin
            mem[fill_q[AW-1:0]] <= in_bits;
        end
    end

    assign in_ready   = (state_q == StCapture);
    assign out_valid  = out_valid_q;
    assign out_bits   = out_bits_q;
    assign fill_level = fill_q;
    assign state      = state_q;
    assign overflow   = overflow_q;
    assign done       = done_q;

endmodule

// File: tb/tb_dsm_capture_buffer.sv
// tb_dsm_capture_buffer: directed bench for dsm_capture_buffer (MOD_BITS=4, DEPTH=8).
// Covers one-shot playback by default and continuous playback when DSM_BUF_LOOP_EN is defined.
module tb_dsm_capture_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       arm = 1'b0;
    logic       play = 1'b0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_bits = 4'h0;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_bits;
    logic       out_ready = 1'b0;
    logic [3:0] fill_level;
    logic [1:0] state;
    logic       overflow;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    dsm_capture_buffer #(
        .MOD_BITS  (4),
        .DEPTH     (8),
        .IDLE_CODE (4'h0)
    ) dut (
        .internal_clk (clk),
        .internal_rst (rst),
        .arm          (arm),
        .play         (play),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_bits      (in_bits),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_bits     (out_bits),
        .out_ready    (out_ready),
        .fill_level   (fill_level),
        .state        (state),
        .overflow     (overflow),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_state"}, 32'(state), 0);
        check({pfx, "_in_ready"}, 32'(in_ready), 0);
        check({pfx, "_out_valid"}, 32'(out_valid), 0);
        check({pfx, "_out_bits"}, 32'(out_bits), 0);
        check({pfx, "_fill"}, 32'(fill_level), 0);
        check({pfx, "_overflow"}, 32'(overflow), 0);
        check({pfx, "_done"}, 32'(done), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_w;
        int          dones;
        logic        fin;
        logic        xfer;

        // Reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("rst");

        // Full capture: 10 words offered, 8 stored, 2 overflow
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("cap_state", 32'(state), 1);
        check("cap_in_ready", 32'(in_ready), 1);
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            in_bits  = 4'(i);
            tick();
            if (i == 7) begin
                check("cap7_fill", 32'(fill_level), 7);
                check("cap7_in_ready", 32'(in_ready), 1);
            end
            if (i == 8) begin
                check("cap8_fill", 32'(fill_level), 8);
                check("cap8_in_ready", 32'(in_ready), 0);
                check("cap8_state", 32'(state), 2);
                check("cap8_overflow", 32'(overflow), 0);
            end
        end
        in_valid = 1'b0;
        check("cap_fill_final", 32'(fill_level), 8);
        check("cap_overflow", 32'(overflow), 1);
        check("cap_state_final", 32'(state), 2);

`ifndef DSM_BUF_LOOP_EN
        // One-shot playback with alternating backpressure
        play = 1'b1;
        tick();
        play = 1'b0;
        check("bp_state", 32'(state), 3);
        check("bp_lat_valid0", 32'(out_valid), 0);
        out_ready = 1'b0;
        tick();
        check("bp_lat_valid1", 32'(out_valid), 1);
        check("bp_lat_word", 32'(out_bits), 1);
        exp_w = 1;
        dones = 0;
        fin   = 1'b0;
        for (int c = 0; c < 40 && !fin; c++) begin
            out_ready = (c % 2 == 0);
            xfer = out_valid && out_ready;
            if (exp_w <= 8) begin
                check("bp_valid", 32'(out_valid), 1);
                check("bp_word", 32'(out_bits), exp_w);
            end
            tick();
            if (xfer) exp_w++;
            if (done) begin
                dones++;
                check("bp_done_valid", 32'(out_valid), 0);
                check("bp_done_bits", 32'(out_bits), 0);
                check("bp_done_state", 32'(state), 2);
                fin = 1'b1;
            end
        end
        out_ready = 1'b0;
        check("bp_words", exp_w, 9);
        check("bp_dones", 32'(dones), 1);
        tick();
        check("bp_done_pulse", 32'(done), 0);
        check("bp_fill_kept", 32'(fill_level), 8);
`endif

        // Early stop: play with the 3rd write; arm during PLAY is ignored
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("es_overflow_clr", 32'(overflow), 0);
        in_valid = 1'b1;
        in_bits  = 4'h3;
        tick();
        in_bits  = 4'h5;
        tick();
        in_bits  = 4'h7;
        play     = 1'b1;
        tick();
        in_valid = 1'b0;
        play     = 1'b0;
        check("es_fill", 32'(fill_level), 3);
        check("es_state", 32'(state), 3);
        check("es_overflow", 32'(overflow), 0);
        check("es_valid0", 32'(out_valid), 0);
        out_ready = 1'b1;
        tick();
        check("es_w0", 32'(out_bits), 3);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("es_w1", 32'(out_bits), 5);
        check("es_arm_ign_state", 32'(state), 3);
        check("es_arm_ign_fill", 32'(fill_level), 3);
        tick();
        check("es_w2", 32'(out_bits), 7);
        tick();
        check("es_done", 32'(done), 1);
`ifdef DSM_BUF_LOOP_EN
        check("es_wrap_valid", 32'(out_valid), 1);
        check("es_wrap_word", 32'(out_bits), 3);
        check("es_wrap_state", 32'(state), 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("es_abort_state", 32'(state), 0);
        check("es_abort_valid", 32'(out_valid), 0);
`else
        check("es_end_valid", 32'(out_valid), 0);
        check("es_end_state", 32'(state), 2);
`endif
        out_ready = 1'b0;

        // Two words 0xA, 0xB
        arm = 1'b1;
        tick();
        arm = 1'b0;
        in_valid = 1'b1;
        in_bits  = 4'hA;
        tick();
        in_bits  = 4'hB;
        tick();
        in_valid = 1'b0;
        check("two_fill", 32'(fill_level), 2);
        check("two_state", 32'(state), 1);
        play = 1'b1;
        tick();
        play = 1'b0;
        out_ready = 1'b1;
        tick();
        check("two_w0", 32'(out_bits), 'hA);
`ifdef DSM_BUF_LOOP_EN
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("loop_valid", 32'(out_valid), 1);
            check("loop_word", 32'(out_bits), (k % 2 == 1) ? 'hB : 'hA);
            check("loop_done", 32'(done), (k % 2 == 0) ? 1 : 0);
            check("loop_state", 32'(state), 3);
        end
        // Abort while the last word transfers: no done pulse
        abort = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b0;
        check("loop_abort_state", 32'(state), 0);
        check("loop_abort_valid", 32'(out_valid), 0);
        check("loop_abort_done", 32'(done), 0);
        check("loop_abort_in_ready", 32'(in_ready), 0);
        check("loop_abort_fill", 32'(fill_level), 0);
`else
        tick();
        check("two_w1", 32'(out_bits), 'hB);
        check("two_w1_done", 32'(done), 0);
        tick();
        out_ready = 1'b0;
        check("two_done", 32'(done), 1);
        check("two_end_state", 32'(state), 2);
        // abort beats arm from READY
        abort = 1'b1;
        arm   = 1'b1;
        tick();
        abort = 1'b0;
        arm   = 1'b0;
        check("prio_state", 32'(state), 0);
        check("prio_in_ready", 32'(in_ready), 0);
        check("prio_fill", 32'(fill_level), 0);
`endif

        // Reset in the middle of PLAY
        arm = 1'b1;
        tick();
        arm = 1'b0;
        in_valid = 1'b1;
        in_bits  = 4'h6;
        tick();
        in_bits  = 4'h9;
        tick();
        in_valid = 1'b0;
        play = 1'b1;
        tick();
        play = 1'b0;
        tick();
        check("mp_word", 32'(out_bits), 6);
        in_valid = 1'b1;
        in_bits  = 4'hF;
        tick();
        in_valid = 1'b0;
        check("mp_overflow", 32'(overflow), 1);
        check("mp_hold_word", 32'(out_bits), 6);
        check("mp_hold_valid", 32'(out_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("mprst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
